mc_control_unit_v2: RTL and testbench

- Second-generation multicycle MIPS control unit: one Moore FSM plus an internal ALU decoder in a single block.
- Drives the shared-memory multicycle datapath (PC, IR, register file, ALU, ALUOut).
- Over the first generation it adds:
  - a memory-ready handshake (wait states);
  - addi, ori, j and optional bne instructions;
  - illegal-instruction detection;
  - a parametrised ALU control width.

---
 rtl/mc_control_unit_v2_if.sv | 35 +++
 rtl/mc_control_unit_v2.sv | 197 +++++++++++++++++++
 tb/tb_mc_control_unit_v2.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_control_unit_v2_if.sv
// Control-unit <-> multicycle datapath bundle: instruction fields, memory-ready and datapath controls.
// mem_ready: memory completes the access presented this cycle; the FSM holds FETCH/MEMRD/MEMWR until it is 1.
interface mc_control_unit_v2_if #(
  parameter int ALUCTRL_W = 3
);
  logic [5:0]           Opcode;
  logic [5:0]           Funct;
  logic                 mem_ready;
  logic                 MemtoReg;
  logic                 RegDst;
  logic                 IorD;
  logic                 ALUSrcA;
  logic                 IRWrite;
  logic                 MemWrite;
  logic                 PCWrite;
  logic                 RegWrite;
  logic                 Branch;
  logic                 BranchNe;
  logic                 ImmZext;
  logic [1:0]           ALUSrcB;
  logic [1:0]           PCSrc;
  logic [ALUCTRL_W-1:0] ALUControl;

  modport master (
    input  Opcode, Funct, mem_ready,
    output MemtoReg, RegDst, IorD, ALUSrcA, IRWrite, MemWrite, PCWrite,
           RegWrite, Branch, BranchNe, ImmZext, ALUSrcB, PCSrc, ALUControl
  );

  modport slave (
    output Opcode, Funct, mem_ready,
    input  MemtoReg, RegDst, IorD, ALUSrcA, IRWrite, MemWrite, PCWrite,
           RegWrite, Branch, BranchNe, ImmZext, ALUSrcB, PCSrc, ALUControl
  );
endinterface

// File: rtl/mc_control_unit_v2.sv
// Multicycle MIPS control unit: Moore FSM with memory wait states and an internal ALU decoder.
// Optional MC_CTRL_PERF_EN adds a fetch_count output counting IRWrite cycles.
module mc_control_unit_v2 #(
  parameter int ALUCTRL_W   = 3,
  parameter int BNE_SUPPORT = 1,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  mc_control_unit_v2_if.master  bus,
  output logic                  illegal,
`ifdef MC_CTRL_PERF_EN
  output logic [CNT_W-1:0]      fetch_count,
`endif
  output logic [3:0]            state_o
);

  if (ALUCTRL_W < 3 || CNT_W < 1) begin : g_bad_param
    $error("mc_control_unit_v2: ALUCTRL_W must be >= 3 and CNT_W >= 1");
  end

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTYPE  = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDI   = 4'd9,
    S_ORI    = 4'd10,
    S_IMMWB  = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  state_t     state_q, state_d;
  logic       is_sw_q, is_sw_d;
  logic       bne_q, bne_d;
  logic       dec_illegal;
  logic       funct_ok;
  logic [2:0] funct_alu;
  logic [2:0] alu3;

  // Opcode is only valid in DECODE, so the lw/sw and beq/bne choices are remembered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      is_sw_q <= 1'b0;
      bne_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      is_sw_q <= is_sw_d;
      bne_q   <= bne_d;
    end
  end

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = 3'b010;
    case (bus.Funct)
      6'b100000: funct_alu = 3'b010;
      6'b100010: funct_alu = 3'b110;
      6'b100100: funct_alu = 3'b000;
      6'b100101: funct_alu = 3'b001;
      6'b101010: funct_alu = 3'b111;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    is_sw_d     = is_sw_q;
    bne_d       = bne_q;
    dec_illegal = 1'b0;
    case (state_q)
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        is_sw_d = 1'b0;
        bne_d   = 1'b0;
        case (bus.Opcode)
          OP_LW:    state_d = S_MEMADR;
          OP_SW:    begin state_d = S_MEMADR; is_sw_d = 1'b1; end
          OP_RTYPE: begin
            state_d     = funct_ok ? S_RTYPE : S_FETCH;
            dec_illegal = !funct_ok;
          end
          OP_BEQ:   state_d = S_BEQ;
          OP_BNE:   begin
            if (BNE_SUPPORT != 0) begin
              state_d = S_BEQ;
              bne_d   = 1'b1;
            end else begin
              state_d     = S_FETCH;
              dec_illegal = 1'b1;
            end
          end
          OP_ADDI:  state_d = S_ADDI;
          OP_ORI:   state_d = S_ORI;
          OP_J:     state_d = S_JUMP;
          default:  begin state_d = S_FETCH; dec_illegal = 1'b1; end
        endcase
      end
      S_MEMADR: state_d = is_sw_q ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
      S_RTYPE:  state_d = S_ALUWB;
      S_ADDI:   state_d = S_IMMWB;
      S_ORI:    state_d = S_IMMWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Outputs are forced low while rst is high so no strobe can leak during an aborted instruction.
  always_comb begin
    bus.MemtoReg = 1'b0;
    bus.RegDst   = 1'b0;
    bus.IorD     = 1'b0;
    bus.ALUSrcA  = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.PCWrite  = 1'b0;
    bus.RegWrite = 1'b0;
    bus.Branch   = 1'b0;
    bus.BranchNe = 1'b0;
    bus.ImmZext  = 1'b0;
    bus.ALUSrcB  = 2'b00;
    bus.PCSrc    = 2'b00;
    illegal      = 1'b0;
    alu3         = 3'b000;
    if (!rst) begin
      alu3 = 3'b010;
      case (state_q)
        S_FETCH: begin
          bus.ALUSrcB = 2'b01;
          bus.IRWrite = bus.mem_ready;
          bus.PCWrite = bus.mem_ready;
        end
        S_DECODE: begin
          bus.ALUSrcB = 2'b11;
          illegal     = dec_illegal;
        end
        S_MEMADR: begin bus.ALUSrcA = 1'b1; bus.ALUSrcB = 2'b10; end
        S_MEMRD:  bus.IorD = 1'b1;
        S_MEMWB:  begin bus.MemtoReg = 1'b1; bus.RegWrite = 1'b1; end
        S_MEMWR:  begin bus.IorD = 1'b1; bus.MemWrite = bus.mem_ready; end
        S_RTYPE:  begin bus.ALUSrcA = 1'b1; alu3 = funct_alu; end
        S_ALUWB:  begin bus.RegDst = 1'b1; bus.RegWrite = 1'b1; end
        S_BEQ: begin
          bus.ALUSrcA  = 1'b1;
          alu3         = 3'b110;
          bus.PCSrc    = 2'b01;
          bus.Branch   = 1'b1;
          bus.BranchNe = bne_q;
        end
        S_ADDI:   begin bus.ALUSrcA = 1'b1; bus.ALUSrcB = 2'b10; end
        S_ORI: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = 2'b10;
          alu3        = 3'b001;
          bus.ImmZext = 1'b1;
        end
        S_IMMWB:  bus.RegWrite = 1'b1;
        S_JUMP:   begin bus.PCSrc = 2'b10; bus.PCWrite = 1'b1; end
        default:  ;
      endcase
    end
    bus.ALUControl = ALUCTRL_W'(alu3);
  end

  assign state_o = state_q;

`ifdef MC_CTRL_PERF_EN
  logic [CNT_W-1:0] fetch_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count_q <= '0;
    end else if (bus.IRWrite) begin
      fetch_count_q <= fetch_count_q + 1'b1;
    end
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_mc_control_unit_v2.sv
// Bench for mc_control_unit_v2: per-instruction cycle plans built from the instruction rules, random stream.
module tb_mc_control_unit_v2;

  logic       clk = 1'b0;
  logic       rst;
  logic       illegal, illegal0;
  logic [3:0] state, state0;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] fcount, fcount0;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mc_control_unit_v2_if #(.ALUCTRL_W(4)) dp ();
  mc_control_unit_v2_if #(.ALUCTRL_W(3)) dp0 ();

  assign dp0.Opcode    = dp.Opcode;
  assign dp0.Funct     = dp.Funct;
  assign dp0.mem_ready = dp.mem_ready;

  mc_control_unit_v2 #(.ALUCTRL_W(4), .BNE_SUPPORT(1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .bus(dp), .illegal(illegal),
`ifdef MC_CTRL_PERF_EN
    .fetch_count(fcount),
`endif
    .state_o(state)
  );

  mc_control_unit_v2 #(.ALUCTRL_W(3), .BNE_SUPPORT(0), .CNT_W(32)) dut0 (
    .clk(clk), .rst(rst), .bus(dp0), .illegal(illegal0),
`ifdef MC_CTRL_PERF_EN
    .fetch_count(fcount0),
`endif
    .state_o(state0)
  );

  typedef struct packed {
    logic       m2r, regdst, iord, srca, irw, memw, pcw, regw, br, brne, zext;
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    logic [3:0] aluc;
    logic       ill;
  } ctl_t;

  // scoreboard: one expected control vector per cycle, with the mem_ready to drive and whether IR must be held
  logic [19:0] exp_q[$];
  bit          mr_q[$];
  bit          hold_q[$];

  function automatic ctl_t got_main();
    got_main = {dp.MemtoReg, dp.RegDst, dp.IorD, dp.ALUSrcA, dp.IRWrite, dp.MemWrite,
                dp.PCWrite, dp.RegWrite, dp.Branch, dp.BranchNe, dp.ImmZext,
                dp.ALUSrcB, dp.PCSrc, dp.ALUControl, illegal};
  endfunction

  function automatic ctl_t idle();
    ctl_t v;
    v      = '0;
    v.aluc = 4'b0010;
    return v;
  endfunction

  function automatic logic [3:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      default:   return 4'b0010;
    endcase
  endfunction

  function automatic bit legal_instr(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b100011, 6'b101011, 6'b000100, 6'b000101,
      6'b001000, 6'b001101, 6'b000010: return 1'b1;
      6'b000000: return (fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
                         fn == 6'b100101 || fn == 6'b101010);
      default:   return 1'b0;
    endcase
  endfunction

  task automatic push_cycle(input ctl_t v, input bit mr, input bit hold);
    exp_q.push_back(v);
    mr_q.push_back(mr);
    hold_q.push_back(hold);
  endtask

  // Reference model: expand one instruction into its expected per-cycle control vectors.
  task automatic plan(input logic [5:0] op, input logic [5:0] fn, input int fwait, input int mwait);
    ctl_t v;
    for (int i = 0; i < fwait; i++) begin
      v = idle(); v.srcb = 2'b01;
      push_cycle(v, 1'b0, 1'b0);
    end
    v = idle(); v.srcb = 2'b01; v.irw = 1'b1; v.pcw = 1'b1;
    push_cycle(v, 1'b1, 1'b0);
    v = idle(); v.srcb = 2'b11; v.ill = !legal_instr(op, fn);
    push_cycle(v, 1'($urandom_range(0, 1)), 1'b1);
    if (v.ill) return;
    case (op)
      6'b100011, 6'b101011: begin
        v = idle(); v.srca = 1'b1; v.srcb = 2'b10;
        push_cycle(v, 1'($urandom_range(0, 1)), 1'b0);
        for (int i = 0; i < mwait; i++) begin
          v = idle(); v.iord = 1'b1;
          push_cycle(v, 1'b0, 1'b0);
        end
        v = idle(); v.iord = 1'b1; v.memw = (op == 6'b101011);
        push_cycle(v, 1'b1, 1'b0);
        if (op == 6'b100011) begin
          v = idle(); v.m2r = 1'b1; v.regw = 1'b1;
          push_cycle(v, 1'($urandom_range(0, 1)), 1'b0);
        end
      end
      6'b000000: begin
        v = idle(); v.srca = 1'b1; v.aluc = alu_of(fn);
        push_cycle(v, 1'($urandom_range(0, 1)), 1'b1);
        v = idle(); v.regdst = 1'b1; v.regw = 1'b1;
        push_cycle(v, 1'($urandom_range(0, 1)), 1'b0);
      end
      6'b000100, 6'b000101: begin
        v = idle(); v.srca = 1'b1; v.aluc = 4'b0110; v.pcsrc = 2'b01;
        v.br = 1'b1; v.brne = (op == 6'b000101);
        push_cycle(v, 1'($urandom_range(0, 1)), 1'b0);
      end
      6'b001000, 6'b001101: begin
        v = idle(); v.srca = 1'b1; v.srcb = 2'b10;
        if (op == 6'b001101) begin v.aluc = 4'b0001; v.zext = 1'b1; end
        push_cycle(v, 1'($urandom_range(0, 1)), 1'b0);
        v = idle(); v.regw = 1'b1;
        push_cycle(v, 1'($urandom_range(0, 1)), 1'b0);
      end
      default: begin
        v = idle(); v.pcsrc = 2'b10; v.pcw = 1'b1;
        push_cycle(v, 1'($urandom_range(0, 1)), 1'b0);
      end
    endcase
  endtask

  // Driver + scoreboard: one planned cycle per clock; IR fields are scrambled whenever they must not matter.
  task automatic run_plan(input string tag, input logic [5:0] op, input logic [5:0] fn);
    logic [19:0] e, g;
    bit m, h;
    int cyc;
    cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m = mr_q.pop_front();
      h = hold_q.pop_front();
      @(posedge clk); #1;
      dp.mem_ready = m;
      if (h) begin
        dp.Opcode = op;
        dp.Funct  = fn;
      end else begin
        dp.Opcode = 6'($urandom);
        dp.Funct  = 6'($urandom);
      end
      @(negedge clk);
      g = got_main();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s op=%b fn=%b cycle %0d: got %h expected %h", tag, op, fn, cyc, g, e);
      end
      cyc++;
    end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    dp.mem_ready = 1'b0;
    dp.Opcode    = 6'b0;
    dp.Funct     = 6'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      dp.mem_ready = 1'b1;
      dp.Opcode    = 6'($urandom);
      dp.Funct     = 6'($urandom);
      @(negedge clk);
      checks++;
      if (got_main() !== 20'h0 || state !== 4'd0) begin
        errors++;
        $display("FAIL reset_outputs: got %h state %0d expected all zero", got_main(), state);
      end
    end
`ifdef MC_CTRL_PERF_EN
    checks++;
    if (fcount !== 32'd0) begin
      errors++;
      $display("FAIL reset_fetch_count: got %0d expected 0", fcount);
    end
`endif
    do_reset();
  endtask

  task automatic test_rtype_sub();
    plan(6'b000000, 6'b100010, 0, 0);
    run_plan("rtype_sub", 6'b000000, 6'b100010);
  endtask

  task automatic test_lw_wait();
    plan(6'b100011, 6'($urandom), 0, 2);
    run_plan("lw_wait", 6'b100011, 6'b0);
  endtask

  task automatic test_sw_wait();
    plan(6'b101011, 6'b0, 1, 1);
    run_plan("sw_wait", 6'b101011, 6'b0);
  endtask

  task automatic test_bne();
    plan(6'b000101, 6'b0, 0, 0);
    run_plan("bne", 6'b000101, 6'b0);
    plan(6'b000100, 6'b0, 0, 0);
    run_plan("beq", 6'b000100, 6'b0);
  endtask

  // Second instance has bne decoding disabled; both see identical inputs.
  task automatic test_bne_disabled();
    @(posedge clk); #1;
    dp.mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (dp0.IRWrite !== 1'b1) begin
      errors++;
      $display("FAIL bne_off_fetch: IRWrite got %b expected 1", dp0.IRWrite);
    end
    @(posedge clk); #1;
    dp.mem_ready = 1'b0;
    dp.Opcode    = 6'b000101;
    @(negedge clk);
    checks++;
    if (illegal0 !== 1'b1 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL bne_off_decode: illegal(off)=%b illegal(on)=%b expected 1/0", illegal0, illegal);
    end
    @(posedge clk); #1;
    dp.Opcode = 6'($urandom);
    @(negedge clk);
    checks++;
    if (illegal0 !== 1'b0 || dp0.ALUSrcB !== 2'b01 || dp0.IorD !== 1'b0 ||
        dp0.IRWrite !== 1'b0 || dp0.Branch !== 1'b0 || dp0.RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL bne_off_refetch: ALUSrcB=%b Branch=%b illegal=%b expected 01/0/0",
               dp0.ALUSrcB, dp0.Branch, illegal0);
    end
    checks++;
    if (dp.Branch !== 1'b1 || dp.BranchNe !== 1'b1 || dp.ALUControl !== 4'b0110) begin
      errors++;
      $display("FAIL bne_on_branch: Branch=%b BranchNe=%b ALUControl=%b expected 1/1/0110",
               dp.Branch, dp.BranchNe, dp.ALUControl);
    end
  endtask

  task automatic test_illegal();
    plan(6'b111111, 6'b0, 0, 0);
    run_plan("illegal_op", 6'b111111, 6'b0);
    plan(6'b000000, 6'b000111, 0, 0);
    run_plan("illegal_funct", 6'b000000, 6'b000111);
  endtask

  task automatic test_midreset();
    @(posedge clk); #1;
    dp.mem_ready = 1'b1;
    @(posedge clk); #1;
    dp.mem_ready = 1'b0;
    dp.Opcode    = 6'b101011;
    @(posedge clk); #1;
    dp.Opcode    = 6'($urandom);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (dp.IorD !== 1'b1 || dp.MemWrite !== 1'b0) begin
      errors++;
      $display("FAIL midrst_memwr: IorD=%b MemWrite=%b expected 1/0", dp.IorD, dp.MemWrite);
    end
    @(posedge clk); #2;
    dp.mem_ready = 1'b1;
    rst          = 1'b1;
    #1;
    checks++;
    if (got_main() !== 20'h0 || state !== 4'd0) begin
      errors++;
      $display("FAIL midrst_async: got %h state %0d expected all zero", got_main(), state);
    end
    dp.mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    plan(6'b000010, 6'b0, 0, 0);
    run_plan("after_reset_j", 6'b000010, 6'b0);
  endtask

  task automatic test_ori_addi();
    plan(6'b001101, 6'b0, 0, 0);
    run_plan("ori", 6'b001101, 6'b0);
    plan(6'b001000, 6'b0, 2, 0);
    run_plan("addi", 6'b001000, 6'b0);
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops[9] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                           6'b001000, 6'b001101, 6'b000010, 6'b111111};
    logic [5:0] fns[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
    logic [5:0] op, fn;
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 8)];
      fn = fns[$urandom_range(0, 5)];
      plan(op, fn, $urandom_range(0, 2), $urandom_range(0, 3));
      run_plan("random", op, fn);
    end
  endtask

`ifdef MC_CTRL_PERF_EN
  task automatic test_perf();
    do_reset();
    plan(6'b000000, 6'b100000, 1, 0);
    run_plan("perf_r", 6'b000000, 6'b100000);
    plan(6'b100011, 6'b0, 0, 1);
    run_plan("perf_lw", 6'b100011, 6'b0);
    plan(6'b000010, 6'b0, 2, 0);
    run_plan("perf_j", 6'b000010, 6'b0);
    checks++;
    if (fcount !== 32'd3) begin
      errors++;
      $display("FAIL perf_count: got %0d expected 3", fcount);
    end
  endtask
`endif

  initial begin
    dp.mem_ready = 1'b0;
    dp.Opcode    = 6'b0;
    dp.Funct     = 6'b0;
    test_reset();
    test_rtype_sub();
    test_lw_wait();
    test_sw_wait();
    test_bne();
    test_bne_disabled();
    test_illegal();
    test_ori_addi();
    test_midreset();
    test_back_to_back();
`ifdef MC_CTRL_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
